// File: rtl/parallel_out_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parallel_out_pkg
// Purpose  : Shared types and the register update function for parallel_out_bank.
// Revision : 1.0 - initial release
// ============================================================================
package parallel_out_pkg;

  // Widest channel the update function supports; channels zero-extend into it.
  localparam int c_MAX_W = 64;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_SET   = 2'd1,
    OP_CLR   = 2'd2,
    OP_TGL   = 2'd3
  } pout_op_e;

  function automatic logic [c_MAX_W-1:0] apply_op(
    input pout_op_e             op,
    input logic [c_MAX_W-1:0]   cur,
    input logic [c_MAX_W-1:0]   din
  );
    logic [c_MAX_W-1:0] res;
    case (op)
      OP_WRITE: res = din;
      OP_SET:   res = cur | din;
      OP_CLR:   res = cur & ~din;
      OP_TGL:   res = cur ^ din;
      default:  res = din;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pout_channel.sv
`default_nettype none
// ============================================================================
// Module   : pout_channel
// Purpose  : One output channel: data register, op apply, stretched update strobe.
// Revision : 1.0 - initial release
// ============================================================================
module pout_channel
  import parallel_out_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STROBE_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd,
  input  pout_op_e          op,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q,
  output logic              strobe
);

  localparam int                 c_CNT_W = $clog2(STROBE_LEN + 1);
  localparam logic [c_CNT_W-1:0] c_LOAD  = c_CNT_W'(STROBE_LEN);

  logic [DATA_W-1:0]  q_q, q_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [c_MAX_W-1:0] w_next_ext;
  logic               w_unused_ext;

  always_comb begin
    w_next_ext = apply_op(op, c_MAX_W'(q_q), c_MAX_W'(din));
    q_d        = q_q;
    cnt_d      = cnt_q;
    if (upd) begin
      q_d   = w_next_ext[DATA_W-1:0];
      // Every update restarts the count, so the pulse ends STROBE_LEN after the last write.
      cnt_d = c_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign w_unused_ext = ^w_next_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q      = q_q;
  assign strobe = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/parallel_out_bank.sv
`default_nettype none
// ============================================================================
// Module   : parallel_out_bank
// Purpose  : Memory-mapped bank of N_CH output registers with write/set/clear/toggle.
// Revision : 1.0 - initial release
// ============================================================================
module parallel_out_bank
  import parallel_out_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          ADDR_W     = 8,
  parameter int          N_CH       = 4,
  parameter int unsigned BASE_ADDR  = 'hF0,
  parameter int          STROBE_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W-1:0]        regData,
  output logic [N_CH*DATA_W-1:0]   dataOut,
  output logic [N_CH-1:0]          strobe,
  output logic                     wren,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid
);

  localparam int                c_CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [ADDR_W:0]   c_BASE = (ADDR_W + 1)'(BASE_ADDR);
  localparam logic [ADDR_W:0]   c_WIN  = (ADDR_W + 1)'(4 * N_CH);
  localparam logic [ADDR_W:0]   c_NCH  = (ADDR_W + 1)'(N_CH);

  if ((BASE_ADDR + 4 * N_CH) > (64'd1 << ADDR_W)) begin : g_bad_window
    $error("parallel_out_bank: window does not fit in the address space");
  end
  if (STROBE_LEN < 1) begin : g_bad_strobe
    $error("parallel_out_bank: STROBE_LEN must be at least 1");
  end
  if (DATA_W > c_MAX_W) begin : g_bad_width
    $error("parallel_out_bank: DATA_W exceeds supported width");
  end

  logic [ADDR_W:0]   w_addr_ext;
  logic [ADDR_W:0]   w_off;
  logic [ADDR_W:0]   w_div;
  logic [ADDR_W:0]   w_mod;
  logic              w_hit;
  logic              w_rd_hit;
  pout_op_e          w_op;
  logic [c_CH_W-1:0] w_ch;
  logic [DATA_W-1:0] w_rd_sel;
  logic              w_unused_bits;

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // Extra top bit keeps the subtraction from wrapping below BASE_ADDR.
  assign w_addr_ext = {1'b0, address};
  assign w_off      = w_addr_ext - c_BASE;
  assign w_hit      = (w_addr_ext >= c_BASE) && (w_off < c_WIN);
  assign w_div      = w_off / c_NCH;
  assign w_mod      = w_off % c_NCH;
  assign w_op       = pout_op_e'(w_div[1:0]);
  assign w_ch       = w_mod[c_CH_W-1:0];
  assign w_unused_bits = ^{w_div[ADDR_W:2], w_mod};

  assign wren     = we & w_hit;
  assign w_rd_hit = re & w_hit;
  assign w_rd_sel = dataOut[w_ch*DATA_W +: DATA_W];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    pout_channel #(
      .DATA_W     (DATA_W),
      .STROBE_LEN (STROBE_LEN)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .upd    (wren && (w_ch == c_CH_W'(gi))),
      .op     (w_op),
      .din    (regData),
      .q      (dataOut[gi*DATA_W +: DATA_W]),
      .strobe (strobe[gi])
    );
  end

  // Read samples the register before this edge's write lands, giving the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= w_rd_hit;
      if (w_rd_hit) begin
        rd_data_q <= w_rd_sel;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_parallel_out_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_parallel_out_bank
// Purpose  : Directed self-checking bench for parallel_out_bank (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_parallel_out_bank;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic        re;
  logic [7:0]  address;
  logic [7:0]  regData;
  logic [31:0] dataOut;
  logic [3:0]  strobe;
  logic        wren;
  logic [7:0]  rd_data;
  logic        rd_valid;

  int n_tests = 0;
  int n_fail  = 0;

  parallel_out_bank dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .re       (re),
    .address  (address),
    .regData  (regData),
    .dataOut  (dataOut),
    .strobe   (strobe),
    .wren     (wren),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1; address = a; regData = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b0; re = 1'b0; address = 8'h00; regData = 8'h00;
    #2;
    n_tests++;
    if (dataOut !== 32'h0) begin n_fail++; $display("FAIL reset_dataOut got %h exp %h", dataOut, 32'h0); end
    n_tests++;
    if (strobe !== 4'h0) begin n_fail++; $display("FAIL reset_strobe got %h exp %h", strobe, 4'h0); end
    n_tests++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_read got v=%b d=%h exp v=0 d=00", rd_valid, rd_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    we = 1'b1; address = 8'hF1; regData = 8'hA5;
    #1;
    n_tests++;
    if (wren !== 1'b1) begin n_fail++; $display("FAIL write_wren got %b exp 1", wren); end
    tick();
    we = 1'b0;
    n_tests++;
    if (dataOut !== 32'h0000A500) begin n_fail++; $display("FAIL write_data got %h exp %h", dataOut, 32'h0000A500); end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (strobe !== ((k < 4) ? 4'b0010 : 4'b0000)) begin
        n_fail++; $display("FAIL write_strobe cyc%0d got %b exp %b", k, strobe, (k < 4) ? 4'b0010 : 4'b0000);
      end
      tick();
    end
    we = 1'b1; address = 8'hEF; regData = 8'h3C;
    #1;
    n_tests++;
    if (wren !== 1'b0) begin n_fail++; $display("FAIL below_wren got %b exp 0", wren); end
    tick();
    address = 8'h00;
    #1;
    n_tests++;
    if (wren !== 1'b0) begin n_fail++; $display("FAIL zero_wren got %b exp 0", wren); end
    tick();
    we = 1'b0;
    n_tests++;
    if (dataOut !== 32'h0000A500 || strobe !== 4'h0) begin
      n_fail++; $display("FAIL outside_nochange got %h/%b exp %h/0000", dataOut, strobe, 32'h0000A500);
    end
  endtask

  task automatic test_ops();
    do_write(8'hF2, 8'h0F);
    n_tests++;
    if (dataOut !== 32'h000FA500) begin n_fail++; $display("FAIL op_write got %h exp %h", dataOut, 32'h000FA500); end
    do_write(8'hF6, 8'h30);
    n_tests++;
    if (dataOut !== 32'h003FA500) begin n_fail++; $display("FAIL op_set got %h exp %h", dataOut, 32'h003FA500); end
    do_write(8'hFA, 8'h03);
    n_tests++;
    if (dataOut !== 32'h003CA500) begin n_fail++; $display("FAIL op_clr got %h exp %h", dataOut, 32'h003CA500); end
    do_write(8'hFE, 8'hFF);
    n_tests++;
    if (dataOut !== 32'h00C3A500) begin n_fail++; $display("FAIL op_tgl got %h exp %h", dataOut, 32'h00C3A500); end
    repeat (5) tick();
  endtask

  task automatic test_retrigger();
    do_write(8'hF0, 8'h11);
    for (int t = 1; t <= 7; t++) begin
      n_tests++;
      if (strobe[0] !== (t <= 6)) begin
        n_fail++; $display("FAIL retrig_t%0d got %b exp %b", t, strobe[0], (t <= 6));
      end
      if (t == 2) begin
        we = 1'b1; address = 8'hF0; regData = 8'h22;
      end else begin
        we = 1'b0;
      end
      tick();
    end
    n_tests++;
    if (dataOut !== 32'h00C3A522) begin n_fail++; $display("FAIL retrig_data got %h exp %h", dataOut, 32'h00C3A522); end
  endtask

  task automatic test_read();
    do_write(8'hF3, 8'h5A);
    re = 1'b1; address = 8'hF3;
    #1;
    n_tests++;
    if (wren !== 1'b0) begin n_fail++; $display("FAIL read_wren got %b exp 0", wren); end
    tick();
    re = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin
      n_fail++; $display("FAIL read_ch3 got v=%b d=%h exp v=1 d=5a", rd_valid, rd_data);
    end
    we = 1'b1; re = 1'b1; address = 8'hFF; regData = 8'h01;
    tick();
    we = 1'b0; re = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin
      n_fail++; $display("FAIL rw_old got v=%b d=%h exp v=1 d=5a", rd_valid, rd_data);
    end
    n_tests++;
    if (dataOut !== 32'h5BC3A522) begin n_fail++; $display("FAIL rw_update got %h exp %h", dataOut, 32'h5BC3A522); end
    re = 1'b1; address = 8'hEE;
    tick();
    re = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h5A) begin
      n_fail++; $display("FAIL read_outside got v=%b d=%h exp v=0 d=5a", rd_valid, rd_data);
    end
  endtask

  task automatic test_reset_mid();
    repeat (5) tick();
    do_write(8'hF1, 8'h77);
    tick();
    re = 1'b1; address = 8'hF0;
    tick();
    re = 1'b0;
    n_tests++;
    if (strobe !== 4'b0010 || rd_valid !== 1'b1 || rd_data !== 8'h22) begin
      n_fail++; $display("FAIL pre_reset got s=%b v=%b d=%h exp s=0010 v=1 d=22", strobe, rd_valid, rd_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (strobe !== 4'h0) begin n_fail++; $display("FAIL async_strobe got %b exp 0000", strobe); end
    n_tests++;
    if (dataOut !== 32'h0) begin n_fail++; $display("FAIL async_data got %h exp %h", dataOut, 32'h0); end
    n_tests++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_fail++; $display("FAIL async_read got v=%b d=%h exp v=0 d=00", rd_valid, rd_data);
    end
    #1;
    we = 1'b1; address = 8'hF2; regData = 8'h99;
    rst_n = 1'b1;
    tick();
    we = 1'b0;
    n_tests++;
    if (dataOut !== 32'h00990000 || strobe !== 4'b0100) begin
      n_fail++; $display("FAIL post_reset_write got %h/%b exp %h/0100", dataOut, strobe, 32'h00990000);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_ops();
    test_retrigger();
    test_read();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
